param_loader: RTL and testbench
===============================

Name: param_loader

Overview:
- Transmit end of the neuron parameter shift chain. Accepts parallel parameter words over a valid/ready handshake.
- Serialises the words MSB-first onto the chain's serial input, asserting chain_setup only on cycles where a bit is shifted.
- Shifts exactly the chain length in bits, then reports done.
- Simultaneously captures the bits leaving the end of the chain (the previous contents) and returns them as readback words.
- Sits between the host/IO front end and the chain of neurons in the tiny BNN.

Parameters:
- NEURONS, 4, number of neurons in the chain.
- INPUTS, 8, weight bits per neuron.
- BIAS_BITS, 3, bias bits per neuron.
- WORD_BITS, 8, width of in_data and rd_data.
- Derived, not overridable:
  - CHAIN_BITS = NEURONS*(INPUTS+BIAS_BITS); 44 at defaults.
  - WORDS = ceil(CHAIN_BITS/WORD_BITS); 6 at defaults.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- in_data  in  WORD_BITS  parameter word; stream bits MSB-first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- chain_setup  out  1  shift enable to every neuron's setup input.
- chain_param_out  out  1  serial bit to the first neuron's param_in.
- chain_param_in  in  1  param_out of the last neuron.
- rd_data  out  WORD_BITS  readback word, MSB = first bit received.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset (async, takes effect immediately): state IDLE, all counters 0, shift buffers 0. All outputs 0: in_ready, chain_setup, chain_param_out, rd_data, rd_valid, busy, done. Reset mid-load abandons the load; the chain holds a partial image and the host must reload.
- States:
  - IDLE: start -> LOAD. Clears bits_sent, words_taken, readback buffer and rd count.
  - LOAD: serialise the stream. When bits_sent reaches CHAIN_BITS -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- busy = 1 in LOAD and DONE. start is ignored outside IDLE.
- Word buffer: sr[WORD_BITS-1:0] plus bits_in_sr counter.
  - in_ready = LOAD && words_taken < WORDS && (bits_in_sr==0 || (bits_in_sr==1 && chain_setup)).
  - This makes back-to-back words stream with no bubble.
  - On acceptance: sr <= in_data; bits_in_sr <= min(WORD_BITS, CHAIN_BITS - WORD_BITS*words_taken). Leftover low bits of the final word are discarded.
- Serial output is register-driven:
  - chain_param_out = sr[WORD_BITS-1].
  - chain_setup = (bits_in_sr != 0) && LOAD.
  - Each cycle with chain_setup=1: sr shifts left by 1, bits_in_sr decrements, bits_sent increments.
- Latency: the word accepted at edge k shows its MSB with chain_setup=1 in cycle k+1.
- Starvation (in_valid low, buffer empty): chain_setup=0 and the chain holds. No timeout.
- Stream order: farthest neuron first; within a neuron, bias MSB..LSB, then weights MSB..LSB. After CHAIN_BITS setup cycles, every neuron holds its bias/weights exactly.
- Readback:
  - On every edge with chain_setup=1, chain_param_in is shifted into rd_sr from the LSB side.
  - When WORD_BITS bits have been collected, or the CHAIN_BITS-th bit is taken:
    - rd_data <= the collected bits, left-aligned with zero padding;
    - rd_valid pulses one cycle.
  - No backpressure; the consumer must take rd_data on the pulse.
  - rd_data holds its value until the next word.
- done asserts the cycle after the last setup cycle. rd_valid for the final word asserts in the same cycle as done.

Decomposition:
- Shared package holds:
  - CHAIN_BITS, WORDS;
  - the state enum (IDLE, LOAD, DONE);
  - a function for the per-word bit count.
- The package is shared with the neuron and the top level.
- One natural sub-module: param_deserializer, the readback rd_sr/rd_valid packer. It is reusable for a standalone chain reader.

Test Plan:
- NEURONS=1 (11 bits, 2 words). Target bias=3'b101, weights=8'hCA. Send in_data 8'hB9 then 8'h40.
  -> chain_setup high exactly 11 cycles; neuron model holds bias=5 and weights=0xCA; done pulses once, 1 cycle after the last setup.
- Defaults, 6 words with in_valid held high.
  -> chain_setup high 44 consecutive cycles, no bubble; in_ready drops after the 6th word; the low 4 bits of word 6 are ignored.
- in_valid dropped 5 cycles at the word-2/word-3 boundary.
  -> chain_setup low exactly 5 cycles, chain contents frozen; total setup cycles still 44; final image correct.
- Chain preloaded with image A, then image B loaded.
  -> 6 rd_valid pulses; rd_data sequence equals A's input words; last word = top 4 bits of A's word 6, low 4 bits zero.
- reset asserted after 20 setup cycles.
  -> all outputs 0 immediately, asynchronously; a following start plus a full load produces the correct image.
- Protocol checks:
  - start pulsed during LOAD -> no effect on counters, total still 44 setup cycles.
  - in_valid high while IDLE -> in_ready stays 0 and no word is consumed.

Source files
------------

// File: rtl/param_loader_pkg.sv
// Shared definitions for the neuron parameter shift chain: chain geometry,
// loader state encoding and the per-word bit-count helper.
package param_loader_pkg;

   localparam int NEURONS_DEF   = 4;
   localparam int INPUTS_DEF    = 8;
   localparam int BIAS_BITS_DEF = 3;
   localparam int WORD_BITS_DEF = 8;

   function automatic int chain_bits_f(input int neurons, input int inputs, input int bias_bits);
      return neurons * (inputs + bias_bits);
   endfunction

   function automatic int words_f(input int chain_bits, input int word_bits);
      return (chain_bits + word_bits - 1) / word_bits;
   endfunction

   localparam int CHAIN_BITS = chain_bits_f(NEURONS_DEF, INPUTS_DEF, BIAS_BITS_DEF);
   localparam int WORDS      = words_f(CHAIN_BITS, WORD_BITS_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bits of word idx that actually enter the chain; the final word may be partial.
   function automatic int word_bit_count(input int chain_bits, input int word_bits, input int idx);
      int remaining;
      remaining = chain_bits - word_bits * idx;
      return (remaining < word_bits) ? remaining : word_bits;
   endfunction

endpackage

// File: rtl/param_loader_deserializer.sv
// Packs bits leaving the end of the chain into left-aligned readback words,
// flushing a short final word when the last chain bit arrives.
module param_loader_deserializer #(
   parameter int WORD_BITS  = 8,
   parameter int CHAIN_BITS = 44
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 shift_en,
   input  logic                 bit_in,
   output logic [WORD_BITS-1:0] rd_data,
   output logic                 rd_valid
);

   localparam int CNT_W = $clog2(WORD_BITS + 1);
   localparam int TOT_W = $clog2(CHAIN_BITS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BITS);
   localparam logic [TOT_W-1:0] LAST_BIT = TOT_W'(CHAIN_BITS - 1);

   logic [WORD_BITS-1:0] rd_sr_q, rd_sr_d;
   logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic [TOT_W-1:0]     total_q, total_d;
   logic [WORD_BITS-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [WORD_BITS-1:0] shifted;
   logic [CNT_W-1:0]     cnt_next;

   always_comb begin
      rd_sr_d    = rd_sr_q;
      rd_cnt_d   = rd_cnt_q;
      total_d    = total_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      shifted    = {rd_sr_q[WORD_BITS-2:0], bit_in};
      cnt_next   = rd_cnt_q + CNT_W'(1);
      if (clear) begin
         rd_sr_d  = '0;
         rd_cnt_d = '0;
         total_d  = '0;
      end else if (shift_en) begin
         total_d = total_q + TOT_W'(1);
         if (cnt_next == FULL_CNT || total_q == LAST_BIT) begin
            // Left-align so the first bit received lands in the MSB.
            rd_data_d  = shifted << (FULL_CNT - cnt_next);
            rd_valid_d = 1'b1;
            rd_sr_d    = '0;
            rd_cnt_d   = '0;
         end else begin
            rd_sr_d  = shifted;
            rd_cnt_d = cnt_next;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_sr_q    <= '0;
         rd_cnt_q   <= '0;
         total_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_sr_q    <= rd_sr_d;
         rd_cnt_q   <= rd_cnt_d;
         total_q    <= total_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/param_loader.sv
// Transmit end of the neuron parameter chain: serialises host words MSB-first
// into the chain while reading back the previous image from its far end.
module param_loader
   import param_loader_pkg::*;
#(
   parameter int NEURONS   = NEURONS_DEF,
   parameter int INPUTS    = INPUTS_DEF,
   parameter int BIAS_BITS = BIAS_BITS_DEF,
   parameter int WORD_BITS = WORD_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WORD_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 chain_setup,
   output logic                 chain_param_out,
   input  logic                 chain_param_in,
   output logic [WORD_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 busy,
   output logic                 done
);

   localparam int CHAIN_LEN = chain_bits_f(NEURONS, INPUTS, BIAS_BITS);
   localparam int NUM_WORDS = words_f(CHAIN_LEN, WORD_BITS);
   localparam int SENT_W    = $clog2(CHAIN_LEN + 1);
   localparam int TAKEN_W   = $clog2(NUM_WORDS + 1);
   localparam int CNT_W     = $clog2(WORD_BITS + 1);
   localparam logic [SENT_W-1:0]  LAST_BIT  = SENT_W'(CHAIN_LEN - 1);
   localparam logic [TAKEN_W-1:0] WORDS_MAX = TAKEN_W'(NUM_WORDS);

   state_e               state_q, state_d;
   logic [SENT_W-1:0]    bits_sent_q, bits_sent_d;
   logic [TAKEN_W-1:0]   words_taken_q, words_taken_d;
   logic [WORD_BITS-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]     bits_in_sr_q, bits_in_sr_d;
   logic                 load_start;

   always_comb begin
      state_d       = state_q;
      bits_sent_d   = bits_sent_q;
      words_taken_d = words_taken_q;
      sr_d          = sr_q;
      bits_in_sr_d  = bits_in_sr_q;
      load_start    = 1'b0;

      chain_setup     = (state_q == LOAD) && (bits_in_sr_q != '0);
      chain_param_out = sr_q[WORD_BITS-1];
      // Refill on the last shift of a word so consecutive words stream without a bubble.
      in_ready = (state_q == LOAD) && (words_taken_q < WORDS_MAX) &&
                 ((bits_in_sr_q == '0) || (bits_in_sr_q == CNT_W'(1) && chain_setup));
      busy = (state_q != IDLE);
      done = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = LOAD;
               bits_sent_d   = '0;
               words_taken_d = '0;
               sr_d          = '0;
               bits_in_sr_d  = '0;
               load_start    = 1'b1;
            end
         end
         LOAD: begin
            if (chain_setup) begin
               sr_d         = {sr_q[WORD_BITS-2:0], 1'b0};
               bits_in_sr_d = bits_in_sr_q - CNT_W'(1);
               bits_sent_d  = bits_sent_q + SENT_W'(1);
               if (bits_sent_q == LAST_BIT) begin
                  state_d = DONE;
               end
            end
            if (in_valid && in_ready) begin
               sr_d          = in_data;
               bits_in_sr_d  = CNT_W'(word_bit_count(CHAIN_LEN, WORD_BITS, int'(words_taken_q)));
               words_taken_d = words_taken_q + TAKEN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         bits_sent_q   <= '0;
         words_taken_q <= '0;
         sr_q          <= '0;
         bits_in_sr_q  <= '0;
      end else begin
         state_q       <= state_d;
         bits_sent_q   <= bits_sent_d;
         words_taken_q <= words_taken_d;
         sr_q          <= sr_d;
         bits_in_sr_q  <= bits_in_sr_d;
      end
   end

   param_loader_deserializer #(
      .WORD_BITS  (WORD_BITS),
      .CHAIN_BITS (CHAIN_LEN)
   ) u_deser (
      .clk      (clk),
      .reset    (reset),
      .clear    (load_start),
      .shift_en (chain_setup),
      .bit_in   (chain_param_in),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: a one-neuron instance and a default
// four-neuron instance, each driving a behavioural model of the chain.
module tb_param_loader;
   import param_loader_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       s_start = 1'b0, s_in_valid = 1'b0;
   logic [7:0] s_in_data = 8'h00;
   logic       s_in_ready, s_setup, s_pout, s_pin, s_rd_valid, s_busy, s_done;
   logic [7:0] s_rd_data;

   logic       d_start = 1'b0, d_in_valid = 1'b0;
   logic [7:0] d_in_data = 8'h00;
   logic       d_in_ready, d_setup, d_pout, d_pin, d_rd_valid, d_busy, d_done;
   logic [7:0] d_rd_data;

   param_loader #(.NEURONS(1)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .chain_setup(s_setup), .chain_param_out(s_pout),
      .chain_param_in(s_pin), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .busy(s_busy), .done(s_done)
   );

   param_loader u_dut (
      .clk(clk), .reset(reset), .start(d_start), .in_data(d_in_data), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .chain_setup(d_setup), .chain_param_out(d_pout),
      .chain_param_in(d_pin), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
      .busy(d_busy), .done(d_done)
   );

   // Chain model: first bit shifted in ends up at the far (top) end.
   logic [10:0]           chain_s = '0;
   logic [CHAIN_BITS-1:0] chain_d = '0;
   always @(posedge clk) begin
      if (s_setup) chain_s <= {chain_s[9:0], s_pout};
      if (d_setup) chain_d <= {chain_d[CHAIN_BITS-2:0], d_pout};
   end
   assign s_pin = chain_s[10];
   assign d_pin = chain_d[CHAIN_BITS-1];

   int checks = 0;
   int errors = 0;

   logic [7:0] wv [6];
   logic [7:0] r_rd [6];
   int r_setups, r_first, r_last, r_dones, r_done_cyc, r_words, r_ready_late, r_rdn, r_rd_done;

   task automatic run_load(input int stall_len, input int start_mid, input int abort_at);
      int cyc;
      int stalled;
      logic stall_now;
      r_setups = 0; r_first = -1; r_last = -1; r_dones = 0; r_done_cyc = -10;
      r_words = 0; r_ready_late = 0; r_rdn = 0; r_rd_done = 0;
      for (int i = 0; i < 6; i++) r_rd[i] = 8'h00;
      @(negedge clk) d_start = 1'b1;
      @(negedge clk) d_start = 1'b0;
      cyc = 0;
      stalled = 0;
      while (cyc < 300) begin
         if (d_setup) begin
            r_setups++;
            if (r_first < 0) r_first = cyc;
            r_last = cyc;
         end
         if (d_done) begin
            r_dones++;
            r_done_cyc = cyc;
         end
         if (d_rd_valid) begin
            if (r_rdn < 6) r_rd[r_rdn] = d_rd_data;
            r_rdn++;
            if (d_done) r_rd_done = 1;
         end
         if (abort_at > 0 && r_setups == abort_at) break;
         if (r_dones > 0 && cyc >= r_done_cyc + 2) break;
         if (r_words == 6 && d_in_ready) r_ready_late++;
         stall_now = (r_words == 2) && d_in_ready && (stalled < stall_len);
         if (stall_now) stalled++;
         d_in_valid = (r_words < 6) && !stall_now;
         d_in_data  = (r_words < 6) ? wv[r_words] : 8'h00;
         if (d_in_valid && d_in_ready) r_words++;
         d_start = (cyc == start_mid);
         @(negedge clk);
         cyc++;
      end
      d_in_valid = 1'b0;
      d_start    = 1'b0;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({d_in_ready, d_setup, d_pout, d_rd_data, d_rd_valid, d_busy, d_done} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs_default: got %b expected 0",
                  {d_in_ready, d_setup, d_pout, d_rd_data, d_rd_valid, d_busy, d_done});
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({s_in_ready, s_setup, s_pout, s_rd_data, s_rd_valid, s_busy, s_done} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs_small: got %b expected 0",
                  {s_in_ready, s_setup, s_pout, s_rd_data, s_rd_valid, s_busy, s_done});
      end
      reset = 1'b0;
   endtask

   task automatic test_small_chain;
      logic [7:0] sw [2];
      int cyc, words, setups, last, dones, done_cyc;
      sw[0] = 8'hB9; sw[1] = 8'h40;
      words = 0; setups = 0; last = -1; dones = 0; done_cyc = -10;
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      for (cyc = 0; cyc < 60; cyc++) begin
         if (s_setup) begin setups++; last = cyc; end
         if (s_done) begin dones++; done_cyc = cyc; end
         s_in_valid = (words < 2);
         s_in_data  = (words < 2) ? sw[words] : 8'h00;
         if (s_in_valid && s_in_ready) words++;
         @(negedge clk);
      end
      s_in_valid = 1'b0;
      checks++;
      if (setups !== 11) begin errors++; $display("FAIL small_setup_cycles: got %0d expected 11", setups); end
      checks++;
      if (chain_s[10:8] !== 3'b101) begin errors++; $display("FAIL small_bias: got %b expected 101", chain_s[10:8]); end
      checks++;
      if (chain_s[7:0] !== 8'hCA) begin errors++; $display("FAIL small_weights: got %h expected ca", chain_s[7:0]); end
      checks++;
      if (dones !== 1) begin errors++; $display("FAIL small_done_count: got %0d expected 1", dones); end
      checks++;
      if (done_cyc !== last + 1) begin
         errors++; $display("FAIL small_done_timing: done at %0d expected %0d", done_cyc, last + 1);
      end
   endtask

   task automatic test_stream;
      wv[0] = 8'h3C; wv[1] = 8'hA5; wv[2] = 8'h0F; wv[3] = 8'hF0; wv[4] = 8'h96; wv[5] = 8'h7E;
      run_load(0, 10, 0);
      checks++;
      if (r_setups !== 44) begin errors++; $display("FAIL stream_setup_cycles: got %0d expected 44", r_setups); end
      checks++;
      if ((r_last - r_first + 1 - r_setups) !== 0) begin
         errors++; $display("FAIL stream_bubbles: got %0d expected 0", r_last - r_first + 1 - r_setups);
      end
      checks++;
      if (r_words !== 6) begin errors++; $display("FAIL stream_words_taken: got %0d expected 6", r_words); end
      checks++;
      if (r_ready_late !== 0) begin errors++; $display("FAIL stream_ready_after_last: got %0d expected 0", r_ready_late); end
      checks++;
      if (chain_d !== 44'h3CA50FF0967) begin
         errors++; $display("FAIL stream_image: got %h expected 3ca50ff0967", chain_d);
      end
      checks++;
      if (r_dones !== 1) begin errors++; $display("FAIL stream_done_count: got %0d expected 1", r_dones); end
      checks++;
      if (r_done_cyc !== r_last + 1) begin
         errors++; $display("FAIL stream_done_timing: done at %0d expected %0d", r_done_cyc, r_last + 1);
      end
      checks++;
      if (r_rdn !== 6 || r_rd[0] !== 8'h00) begin
         errors++; $display("FAIL stream_readback_zero: got %0d words first %h expected 6 words first 00", r_rdn, r_rd[0]);
      end
   endtask

   task automatic test_idle_valid;
      int bad;
      bad = 0;
      d_in_valid = 1'b1;
      d_in_data  = 8'hAA;
      repeat (5) begin
         @(negedge clk);
         if (d_in_ready || d_setup || d_busy) bad++;
      end
      d_in_valid = 1'b0;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL idle_in_ready: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_stall_readback;
      logic [7:0] exp_rd [6];
      exp_rd[0] = 8'h3C; exp_rd[1] = 8'hA5; exp_rd[2] = 8'h0F;
      exp_rd[3] = 8'hF0; exp_rd[4] = 8'h96; exp_rd[5] = 8'h70;
      wv[0] = 8'h12; wv[1] = 8'h34; wv[2] = 8'h56; wv[3] = 8'h78; wv[4] = 8'h9A; wv[5] = 8'hBC;
      run_load(5, -1, 0);
      checks++;
      if (r_setups !== 44) begin errors++; $display("FAIL stall_setup_cycles: got %0d expected 44", r_setups); end
      checks++;
      if ((r_last - r_first + 1 - r_setups) !== 5) begin
         errors++; $display("FAIL stall_gap_cycles: got %0d expected 5", r_last - r_first + 1 - r_setups);
      end
      checks++;
      if (chain_d !== 44'h123456789AB) begin
         errors++; $display("FAIL stall_image: got %h expected 123456789ab", chain_d);
      end
      checks++;
      if (r_rdn !== 6) begin errors++; $display("FAIL readback_count: got %0d expected 6", r_rdn); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (r_rd[i] !== exp_rd[i]) begin
            errors++; $display("FAIL readback_word%0d: got %h expected %h", i, r_rd[i], exp_rd[i]);
         end
      end
      checks++;
      if (r_rd_done !== 1) begin errors++; $display("FAIL readback_last_with_done: got %0d expected 1", r_rd_done); end
   endtask

   task automatic test_reset_mid_load;
      for (int i = 0; i < 6; i++) wv[i] = 8'hFF;
      run_load(0, -1, 20);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({d_in_ready, d_setup, d_pout, d_rd_data, d_rd_valid, d_busy, d_done} !== 13'd0) begin
         errors++;
         $display("FAIL midload_reset_outputs: got %b expected 0",
                  {d_in_ready, d_setup, d_pout, d_rd_data, d_rd_valid, d_busy, d_done});
      end
      @(negedge clk) reset = 1'b0;
      wv[0] = 8'h01; wv[1] = 8'h23; wv[2] = 8'h45; wv[3] = 8'h67; wv[4] = 8'h89; wv[5] = 8'hAB;
      run_load(0, -1, 0);
      checks++;
      if (r_setups !== 44) begin errors++; $display("FAIL reload_setup_cycles: got %0d expected 44", r_setups); end
      checks++;
      if (chain_d !== 44'h0123456789A) begin
         errors++; $display("FAIL reload_image: got %h expected 0123456789a", chain_d);
      end
   endtask

   initial begin
      test_reset();
      test_small_chain();
      test_stream();
      test_idle_valid();
      test_stall_readback();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
